// File: rtl/freespace_update_arbiter.sv
// Round-robin serialiser for per-port freespace update packets.
// One holding slot per port feeds a registered valid/ready output stage.
module freespace_update_arbiter #(
  parameter int PACKET_BITS  = 97,
  parameter int NUM_IN_PORTS = 7,
  parameter int CNT_BITS     = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_IN_PORTS-1:0]             freespace_update,
  input  logic [PACKET_BITS*NUM_IN_PORTS-1:0] packet_from_input_ports,
  input  logic                                out_ready,
  output logic [PACKET_BITS-1:0]              stream_out,
  output logic                                out_vld,
  output logic [NUM_IN_PORTS-1:0]             pending,
  output logic [CNT_BITS-1:0]                 coalesce_cnt
);

  localparam int PTR_W = (NUM_IN_PORTS > 1) ? $clog2(NUM_IN_PORTS) : 1;
  localparam int INC_W = $clog2(NUM_IN_PORTS + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                   state;
  state_t                   state_d;
  logic [PACKET_BITS-1:0]   slot [NUM_IN_PORTS];
  logic [PACKET_BITS-1:0]   data_q;
  logic [PACKET_BITS-1:0]   data_d;
  logic [PTR_W-1:0]         rr_ptr;
  logic                     can_grant;
  logic                     found;
  logic                     grant_vld;
  logic [PTR_W-1:0]         grant_idx;
  logic [NUM_IN_PORTS-1:0]  grant_oh;
  logic [NUM_IN_PORTS-1:0]  coal;
  logic [INC_W-1:0]         coal_n;
  logic [CNT_BITS:0]        cnt_sum;
  logic [CNT_BITS-1:0]      cnt_next;

  assign can_grant = (state == IDLE) || out_ready;
  assign grant_vld = found && can_grant;

  // First pending port at or after rr_ptr, wrapping around.
  always_comb begin : grant_search
    int j;
    j         = 0;
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_IN_PORTS; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_IN_PORTS) j = j - NUM_IN_PORTS;
      if (!found && pending[j]) begin
        found     = 1'b1;
        grant_idx = PTR_W'(j);
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    coal_n   = '0;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      grant_oh[i] = grant_vld && (grant_idx == PTR_W'(i));
    end
    // A pulse on the port being granted is a fresh request, not a coalesce.
    coal = freespace_update & pending & ~grant_oh;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      coal_n = coal_n + INC_W'(coal[i]);
    end
    cnt_sum  = {1'b0, coalesce_cnt} + (CNT_BITS+1)'(coal_n);
    cnt_next = cnt_sum[CNT_BITS] ? '1 : cnt_sum[CNT_BITS-1:0];
  end

  always_comb begin
    state_d = state;
    data_d  = data_q;
    unique case (state)
      IDLE: begin
        if (grant_vld) begin
          state_d = HOLD;
          data_d  = slot[grant_idx];
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (grant_vld) begin
            data_d = slot[grant_idx];
          end else begin
            state_d = IDLE;
            data_d  = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      data_q       <= '0;
      pending      <= '0;
      rr_ptr       <= '0;
      coalesce_cnt <= '0;
      for (int i = 0; i < NUM_IN_PORTS; i++) slot[i] <= '0;
    end else begin
      state        <= state_d;
      data_q       <= data_d;
      pending      <= freespace_update | (pending & ~grant_oh);
      coalesce_cnt <= cnt_next;
      if (grant_vld) begin
        rr_ptr <= (grant_idx == PTR_W'(NUM_IN_PORTS-1)) ?
                  '0 : grant_idx + PTR_W'(1);
      end
      for (int i = 0; i < NUM_IN_PORTS; i++) begin
        if (freespace_update[i]) begin
          slot[i] <= packet_from_input_ports[PACKET_BITS*i +: PACKET_BITS];
        end
      end
    end
  end

  assign out_vld    = (state == HOLD);
  assign stream_out = data_q;

endmodule

// File: tb/tb_freespace_update_arbiter.sv
// Bench for freespace_update_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a queue-free slot model.
module tb_freespace_update_arbiter;

  localparam int PB = 97;
  localparam int N  = 7;
  localparam int CW = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    upd = '0;
  logic [PB*N-1:0] bus = '0;
  logic            out_ready = 1'b0;
  logic [PB-1:0]   stream_out;
  logic            out_vld;
  logic [N-1:0]    pending;
  logic [CW-1:0]   coalesce_cnt;

  always #5 clk = ~clk;

  freespace_update_arbiter #(
    .PACKET_BITS(PB),
    .NUM_IN_PORTS(N),
    .CNT_BITS(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .freespace_update(upd),
    .packet_from_input_ports(bus),
    .out_ready(out_ready),
    .stream_out(stream_out),
    .out_vld(out_vld),
    .pending(pending),
    .coalesce_cnt(coalesce_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Inputs as seen by the DUT at the last rising edge.
  logic [N-1:0]    s_upd = '0;
  logic [PB*N-1:0] s_bus = '0;
  logic            s_rdy = 1'b0;
  logic            s_rst = 1'b1;
  logic            s_ok  = 1'b0;

  always @(posedge clk) begin
    s_upd <= upd;
    s_bus <= bus;
    s_rdy <= out_ready;
    s_rst <= reset;
    s_ok  <= 1'b1;
  end

  logic [PB-1:0] m_slot [N];
  logic [N-1:0]  m_pend = '0;
  int            m_ptr = 0;
  bit            m_vld = 1'b0;
  logic [PB-1:0] m_out = '0;
  int            m_cnt = 0;

  task automatic model_step();
    int g;
    logic [N-1:0] old;
    if (s_rst) begin
      m_pend = '0;
      m_ptr  = 0;
      m_vld  = 1'b0;
      m_out  = '0;
      m_cnt  = 0;
      for (int i = 0; i < N; i++) m_slot[i] = '0;
    end else begin
      g   = -1;
      old = m_pend;
      if (!m_vld || s_rdy) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && old[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
      end
      if (g >= 0) begin
        m_out     = m_slot[g];
        m_vld     = 1'b1;
        m_ptr     = (g + 1) % N;
        m_pend[g] = 1'b0;
      end else if (m_vld && s_rdy) begin
        m_vld = 1'b0;
        m_out = '0;
      end
      for (int i = 0; i < N; i++) begin
        if (s_upd[i]) begin
          if (old[i] && i != g && m_cnt < CMAX) m_cnt++;
          m_slot[i] = s_bus[PB*i +: PB];
          m_pend[i] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (s_ok) begin
        model_step();
        chk("m_out_vld", 128'(out_vld), 128'(m_vld));
        chk("m_stream_out", 128'(stream_out), 128'(m_out));
        chk("m_pending", 128'(pending), 128'(m_pend));
        chk("m_coalesce_cnt", 128'(coalesce_cnt), 128'(m_cnt));
      end
    end
  end

  function automatic logic [PB-1:0] pkt_of(int i, int tag);
    return {1'b1, 32'(tag), 32'(i), 32'hC0DE_0000 | 32'(i)};
  endfunction

  function automatic logic [PB-1:0] rand_pkt();
    return {1'($urandom), $urandom, $urandom, $urandom};
  endfunction

  task automatic put(input int i, input logic [PB-1:0] v);
    bus[PB*i +: PB] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    upd   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  localparam logic [PB-1:0] P3 = 97'h1_0000_0000_0000_00AB_CDEF_0123;

  initial begin
    @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("rst_vld", 128'(out_vld), 128'(0));
      chk("rst_stream", 128'(stream_out), 128'(0));
      chk("rst_pending", 128'(pending), 128'(0));
      chk("rst_cnt", 128'(coalesce_cnt), 128'(0));
    end
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("idle_vld", 128'(out_vld), 128'(0));

    // Single port 3
    put(3, P3);
    upd = 7'b0001000;
    @(negedge clk);
    upd = '0;
    chk("p3_pending", 128'(pending), 128'(7'b0001000));
    chk("p3_vld_early", 128'(out_vld), 128'(0));
    @(negedge clk);
    chk("p3_vld", 128'(out_vld), 128'(1));
    chk("p3_data", 128'(stream_out), 128'(P3));
    chk("p3_pend_clr", 128'(pending), 128'(0));
    @(negedge clk);
    chk("p3_consumed", 128'(out_vld), 128'(0));

    // All seven ports, round-robin order then wrap
    do_reset();
    for (int i = 0; i < N; i++) put(i, pkt_of(i, 1));
    upd = '1;
    @(negedge clk);
    upd = '0;
    chk("all_pending", 128'(pending), 128'(7'h7F));
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      chk("rr_order", 128'(stream_out), 128'(pkt_of(k, 1)));
      if (k == N - 1) begin
        put(0, pkt_of(0, 2));
        put(5, pkt_of(5, 2));
        upd = 7'b0100001;
      end
    end
    @(negedge clk);
    upd = '0;
    chk("wrap_gap", 128'(out_vld), 128'(0));
    chk("wrap_pending", 128'(pending), 128'(7'b0100001));
    @(negedge clk);
    chk("wrap_p0", 128'(stream_out), 128'(pkt_of(0, 2)));
    @(negedge clk);
    chk("wrap_p5", 128'(stream_out), 128'(pkt_of(5, 2)));
    @(negedge clk);
    chk("wrap_done", 128'(out_vld), 128'(0));

    // Backpressure with ports 1 and 5 pending
    do_reset();
    out_ready = 1'b0;
    put(1, pkt_of(1, 3));
    put(5, pkt_of(5, 3));
    upd = 7'b0100010;
    @(negedge clk);
    upd = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_hold", 128'(stream_out), 128'(pkt_of(1, 3)));
      chk("bp_pending", 128'(pending), 128'(7'b0100000));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_p5", 128'(stream_out), 128'(pkt_of(5, 3)));
    @(negedge clk);
    chk("bp_done", 128'(out_vld), 128'(0));

    // Coalesce while output stage is busy with port 4
    do_reset();
    out_ready = 1'b0;
    put(4, pkt_of(4, 4));
    upd = 7'b0010000;
    @(negedge clk);
    upd = '0;
    @(negedge clk);
    put(2, pkt_of(2, 'hA));
    upd = 7'b0000100;
    @(negedge clk);
    upd = '0;
    @(negedge clk);
    put(2, pkt_of(2, 'hB));
    upd = 7'b0000100;
    @(negedge clk);
    upd = '0;
    chk("co_cnt", 128'(coalesce_cnt), 128'(1));
    chk("co_pending", 128'(pending), 128'(7'b0000100));
    chk("co_hold", 128'(stream_out), 128'(pkt_of(4, 4)));
    out_ready = 1'b1;
    @(negedge clk);
    chk("co_b", 128'(stream_out), 128'(pkt_of(2, 'hB)));
    @(negedge clk);
    chk("co_single", 128'(out_vld), 128'(0));
    chk("co_pend_clr", 128'(pending), 128'(0));

    // Pulse during the grant cycle: set wins, no coalesce
    put(2, pkt_of(2, 'hC));
    upd = 7'b0000100;
    @(negedge clk);
    put(2, pkt_of(2, 'hD));
    @(negedge clk);
    upd = '0;
    chk("gc_c", 128'(stream_out), 128'(pkt_of(2, 'hC)));
    chk("gc_pending", 128'(pending), 128'(7'b0000100));
    chk("gc_cnt", 128'(coalesce_cnt), 128'(1));
    @(negedge clk);
    chk("gc_d", 128'(stream_out), 128'(pkt_of(2, 'hD)));
    @(negedge clk);
    chk("gc_done", 128'(out_vld), 128'(0));
    chk("gc_cnt2", 128'(coalesce_cnt), 128'(1));

    // Reset while holding with three ports pending (rr_ptr is 3 here)
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) put(i, pkt_of(i, 5));
    upd = 7'b1001011;
    @(negedge clk);
    upd = '0;
    @(negedge clk);
    chk("hr_vld", 128'(out_vld), 128'(1));
    chk("hr_data", 128'(stream_out), 128'(pkt_of(3, 5)));
    chk("hr_pending", 128'(pending), 128'(7'b1000011));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("hr_rst_vld", 128'(out_vld), 128'(0));
    chk("hr_rst_pend", 128'(pending), 128'(0));
    chk("hr_rst_data", 128'(stream_out), 128'(0));
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("hr_no_stale", 128'(out_vld), 128'(0));
    end

    // Counter saturation: every port pulses every cycle, output stalled
    out_ready = 1'b0;
    for (int c = 0; c < 9500; c++) begin
      for (int i = 0; i < N; i++) put(i, rand_pkt());
      upd = '1;
      @(negedge clk);
    end
    upd = '0;
    chk("sat_cnt", 128'(coalesce_cnt), 128'(16'hFFFF));
    @(negedge clk);
    chk("sat_hold", 128'(coalesce_cnt), 128'(16'hFFFF));

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        upd[i] = ($urandom_range(3) == 0);
        put(i, rand_pkt());
      end
      out_ready = ($urandom_range(2) != 0);
      reset = ($urandom_range(199) == 0);
      @(negedge clk);
    end
    upd = '0;
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(negedge clk);
    chk("drain_vld", 128'(out_vld), 128'(0));
    chk("drain_pend", 128'(pending), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
